fft_adc_loader: RTL

Parametrised front-end that streams ADC samples into the FFT's banked input RAM, then launches the transform and waits for completion. It sits between the ADC interface and `fft_top`, driving the shared `iDATA` bus, per-bank write addresses and write enables, `iSTART`, and observing `oRDY`. It generalises the fixed 4-bank, bank-major, N=4096 frame load to any bank count, frame size and fill order, with a valid/ready sample handshake and overrun detection.

---
 rtl/fft_adc_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_adc_loader.sv
// -----------------------------------------------------------------------------
// fft_adc_loader
//
// Streams one frame of ADC samples into the FFT's banked input RAM, then
// launches the transform and waits for it to complete.
//
// Build option:
//   FFT_LOAD_OFFSET_EN  when defined, adds iOFFSET and writes the sample taken
//                       as unsigned minus iOFFSET, saturated to D_BIT-1 bits
//                       signed. When undefined, samples pass through unchanged.
//
// Parameters:
//   N       frame length (power of 2, multiple of BANKS)
//   BANKS   RAM bank count (power of 2)
//   D_BIT   FFT datapath width; samples and write data are D_BIT-1 bits
//   A_BIT   per-bank address width, log2(N/BANKS)
//   ORDER   0 = bank-major fill, 1 = interleaved fill
//   SETTLE  idle cycles between the last RAM write and oFFT_START (0..15)
//
// Ports:
//   iCLK        clock, rising edge
//   iRESET      synchronous active-low reset
//   iARM        request capture of one frame (sampled only in IDLE)
//   iADC_DATA   ADC sample (signed)
//   iADC_VALID  sample valid
//   oADC_READY  high exactly while loading
//   iOFFSET     unsigned DC offset (FFT_LOAD_OFFSET_EN only)
//   oDATA       write data shared by all banks
//   oADDR_WR    packed per-bank write addresses, bank b at [b*A_BIT +: A_BIT]
//   oWE         per-bank write enable, one-hot or zero
//   oFFT_START  one-cycle launch pulse
//   iFFT_RDY    FFT complete (level)
//   oBUSY       high whenever not idle
//   oDONE       one-cycle pulse when the frame's FFT completes
//   oOVERRUN    sticky: a sample arrived while the loader could not take it
// -----------------------------------------------------------------------------
module fft_adc_loader #(
  parameter int N      = 4096,
  parameter int BANKS  = 4,
  parameter int D_BIT  = 16,
  parameter int A_BIT  = $clog2(N / BANKS),
  parameter int ORDER  = 0,
  parameter int SETTLE = 2
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iARM,
  input  logic [D_BIT-2:0]       iADC_DATA,
  input  logic                   iADC_VALID,
  output logic                   oADC_READY,
`ifdef FFT_LOAD_OFFSET_EN
  input  logic [D_BIT-2:0]       iOFFSET,
`endif
  output logic [D_BIT-2:0]       oDATA,
  output logic [BANKS*A_BIT-1:0] oADDR_WR,
  output logic [BANKS-1:0]       oWE,
  output logic                   oFFT_START,
  input  logic                   iFFT_RDY,
  output logic                   oBUSY,
  output logic                   oDONE,
  output logic                   oOVERRUN
);

  localparam int KW    = $clog2(N);
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int DEPTH = N / BANKS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;           // index of the next sample within the frame
  logic [3:0]      settle_cnt;
  logic            wait_first;  // first WAIT cycle: RDY may still be stale

  logic [BW-1:0]    wr_bank;
  logic [A_BIT-1:0] wr_addr;
  logic [D_BIT-2:0] wr_data;

  // Bank/address of sample k. Both divisors are powers of two, so this
  // reduces to bit selects of k.
  // NOTE: every combinational output gets a value on every path (defaults or
  // complete if/else); a path that leaves one unassigned infers a latch.
  always_comb begin
    if (ORDER == 0) begin
      wr_bank = BW'(int'(k) / DEPTH);
      wr_addr = A_BIT'(int'(k) % DEPTH);
    end else begin
      wr_bank = BW'(int'(k) % BANKS);
      wr_addr = A_BIT'(int'(k) / BANKS);
    end
  end

`ifdef FFT_LOAD_OFFSET_EN
  // Offset removal, one bit wider than the sample so the difference of two
  // unsigned D_BIT-1 values cannot overflow; then clamp back to D_BIT-1
  // signed.
  localparam logic signed [D_BIT-1:0] SAT_HI = D_BIT'((1 << (D_BIT - 2)) - 1);
  localparam logic signed [D_BIT-1:0] SAT_LO = D_BIT'(-(1 << (D_BIT - 2)));

  logic signed [D_BIT-1:0] diff;

  always_comb begin
    diff = signed'({1'b0, iADC_DATA}) - signed'({1'b0, iOFFSET});
    if (diff > SAT_HI) begin
      wr_data = SAT_HI[D_BIT-2:0];
    end else if (diff < SAT_LO) begin
      wr_data = SAT_LO[D_BIT-2:0];
    end else begin
      wr_data = diff[D_BIT-2:0];
    end
  end
`else
  always_comb begin
    wr_data = iADC_DATA;
  end
`endif

  // Single-process FSM; every output is a register updated alongside state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK) begin
    // NOTE: reset clears every register, including the write-port outputs,
    // so an abandoned frame leaves nothing asserted toward the RAM.
    if (!iRESET) begin
      state      <= S_IDLE;
      k          <= '0;
      settle_cnt <= '0;
      wait_first <= 1'b0;
      oADC_READY <= 1'b0;
      oDATA      <= '0;
      oADDR_WR   <= '0;
      oWE        <= '0;
      oFFT_START <= 1'b0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oOVERRUN   <= 1'b0;
    end else begin
      // Write port and pulses are idle unless a state below drives them.
      oWE        <= '0;
      oADDR_WR   <= '0;
      oDATA      <= '0;
      oFFT_START <= 1'b0;
      oDONE      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (iARM) begin
            state      <= S_LOAD;
            k          <= '0;
            settle_cnt <= '0;
            oOVERRUN   <= 1'b0;
            oADC_READY <= 1'b1;
            oBUSY      <= 1'b1;
          end
        end

        S_LOAD: begin
          // oADC_READY is high throughout LOAD, so VALID alone is the accept.
          if (iADC_VALID) begin
            oWE                                <= BANKS'(1) << wr_bank;
            oADDR_WR[wr_bank*A_BIT +: A_BIT]   <= wr_addr;
            oDATA                              <= wr_data;
            k                                  <= k + 1'b1;
            if (k == KW'(N - 1)) begin
              k          <= '0;
              settle_cnt <= '0;
              oADC_READY <= 1'b0;
              state      <= (SETTLE == 0) ? S_START : S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            state <= S_START;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_START: begin
          oFFT_START <= 1'b1;
          wait_first <= 1'b1;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first && iFFT_RDY) begin
            oDONE <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          oBUSY <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          oBUSY      <= 1'b0;
          oADC_READY <= 1'b0;
          state      <= S_IDLE;
        end
      endcase

      // A sample offered while the frame is sealed is lost; flag it until the
      // next capture is armed.
      if (iADC_VALID && (state inside {S_SETTLE, S_START, S_WAIT})) begin
        oOVERRUN <= 1'b1;
      end
    end
  end

endmodule
